// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmit FIFO write port among NUM_REQ byte-stream requesters.
//   clk, rst_n          clock, asynchronous active-low reset
//   en_i                arbiter enable; low blocks new grants, never revokes a held one
//   req_valid_i/_data_i/_last_i   per-requester byte stream (requester k owns data bits [8k+7:8k])
//   req_ready_o         per-requester accept, only the granted requester can see it high
//   tx_full_i           transmit FIFO full
//   tx_data_o/tx_write_o  byte and single-cycle write strobe to the FIFO
//   grant_o, busy_o     one-hot current owner, high while a grant is held
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 tx_full_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_write_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, XFER} state_e;
    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      gidx_q, gidx_d, rr_q, rr_d, sel;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               wr_q, wr_d, any_valid, accept, release_c;
    // Scan from the far end toward rr_q+1 so the nearest valid index after the last grant wins.
    always_comb begin
        sel = rr_q;
        any_valid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_i[(int'(rr_q) + i) % NUM_REQ]) begin
                sel = PW'((int'(rr_q) + i) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end
    // Ready is masked during the write strobe so tx_full_i is current before the next accept.
    assign req_ready_o = (state_q == XFER && !tx_full_i && !wr_q) ? grant_q : '0;
    assign accept      = |(req_ready_o & req_valid_i);
    assign release_c   = accept && (req_last_i[gidx_q] || cnt_q == CW'(MAX_BURST - 1));
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        data_d  = accept ? req_data_i[8*gidx_q +: 8] : data_q;
        wr_d    = accept;
        if (state_q == IDLE) begin
            if (en_i && any_valid) begin
                state_d = XFER;
                grant_d = NUM_REQ'(1) << sel;
                gidx_d  = sel;
                cnt_d   = '0;
            end
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            if (release_c) begin
                state_d = IDLE;
                grant_d = '0;
                rr_d    = gidx_q;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= PW'(NUM_REQ - 1);
            cnt_q   <= '0;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end
    assign tx_data_o  = data_q;
    assign tx_write_o = wr_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q == XFER);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level reference model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    logic           clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, tx_full_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0, req_last_i = '0, req_ready_o, grant_o;
    logic [8*N-1:0] req_data_i = '0;
    logic [7:0]     tx_data_o;
    logic           tx_write_o, busy_o;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_full_i(tx_full_i), .tx_data_o(tx_data_o),
        .tx_write_o(tx_write_o), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    logic [8:0] pq [N][$];
    logic [7:0] wlog [$];
    int         glog [$];
    logic [N-1:0] prev_g = '0;
    bit rnd = 0, full_v = 0, en_v = 1;
    // Reference model: who owns the transmitter, who was granted last, bytes taken this grant, pending write.
    int m_own = -1, m_last = N - 1, m_beats = 0;
    bit m_wr = 0;
    logic [7:0] m_data = 8'h00;
    logic [17:0] exp_v;

    function automatic logic [17:0] obs();
        return {grant_o, busy_o, req_ready_o, tx_write_o, tx_data_o};
    endfunction

    function automatic logic [17:0] model_out();
        logic [N-1:0] g, r;
        g = (m_own >= 0) ? N'(1) << m_own : '0;
        r = (!tx_full_i && !m_wr) ? g : '0;
        return {g, m_own >= 0, r, m_wr, m_data};
    endfunction

    function automatic bit quiet();
        for (int k = 0; k < N; k++) if (pq[k].size() > 0) return 0;
        return m_own < 0 && !m_wr;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]       = pq[k].size() > 0 && (!rnd || $urandom_range(3) != 0);
            req_data_i[8*k +: 8] = pq[k].size() > 0 ? pq[k][0][7:0] : 8'h00;
            req_last_i[k]        = pq[k].size() > 0 && pq[k][0][8];
        end
        tx_full_i = full_v;
        en_i      = en_v;
    endtask

    task automatic model_step();
        bit acc;
        int o;
        acc = 0;
        if (m_own >= 0) acc = !tx_full_i && !m_wr && req_valid_i[m_own];
        if (acc) begin
            o = m_own;
            m_data = pq[o][0][7:0];
            m_beats++;
            if (pq[o][0][8] || m_beats == MB) begin
                m_last = o;
                m_own  = -1;
            end
            pq[o].pop_front();
        end else if (m_own < 0 && en_i && req_valid_i != 0) begin
            for (int i = 1; i <= N; i++) begin
                if (req_valid_i[(m_last + i) % N]) begin
                    m_own = (m_last + i) % N;
                    m_beats = 0;
                    break;
                end
            end
        end
        m_wr = acc;
    endtask

    task automatic tick();
        if (tx_write_o) wlog.push_back(tx_data_o);
        if (grant_o != 0 && grant_o != prev_g) for (int k = 0; k < N; k++) if (grant_o[k]) glog.push_back(k);
        prev_g = grant_o;
        model_step();
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        exp_v = model_out();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        for (int k = 0; k < N; k++) pq[k].delete();
        m_own = -1; m_last = N - 1; m_beats = 0; m_wr = 0; m_data = 8'h00;
        full_v = 0; en_v = 1; rnd = 0;
        drive();
        @(negedge clk);
        rst_n = 1;
        wlog.delete(); glog.delete(); prev_g = '0;
        exp_v = model_out();
    endtask

    task automatic push_pkt(input int k, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) pq[k].push_back({i == len - 1, base + 8'(i)});
    endtask

    task automatic test_reset();
        rst_n = 0;
        push_pkt(0, 1, 8'hAA);
        drive();
        repeat (3) @(negedge clk);
        total++;
        if (obs() !== 18'h0) $display("FAIL reset_hold: dut %h required 0", obs()); else passed++;
        apply_reset();
        total++;
        if (obs() !== exp_v) $display("FAIL reset_release: dut %h required %h", obs(), exp_v); else passed++;
    endtask

    task automatic test_single();
        wlog.delete(); glog.delete();
        push_pkt(1, 3, 8'h41);
        drive();
        exp_v = model_out();
        for (int c = 0; c < 40 && !quiet(); c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL single cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        total++;
        if (!quiet()) $display("FAIL single_timeout: dut busy %b required drained", busy_o); else passed++;
        total++;
        if (wlog.size() != 3 || wlog[0] !== 8'h41 || wlog[1] !== 8'h42 || wlog[2] !== 8'h43)
            $display("FAIL single_bytes: dut %p required 41 42 43", wlog);
        else passed++;
        total++;
        if (glog.size() != 1 || glog[0] != 1) $display("FAIL single_grant: dut %p required {1}", glog); else passed++;
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int p = 0; p < 2; p++) for (int k = 0; k < N; k++) push_pkt(k, 1, 8'h10 + 8'(k));
        drive();
        exp_v = model_out();
        for (int c = 0; c < 100 && !quiet(); c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL fair cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        for (int i = 0; i < 2 * N; i++) begin
            total++;
            if (wlog.size() <= i || wlog[i] !== 8'h10 + 8'(i % N) || glog.size() <= i || glog[i] != i % N)
                $display("FAIL fair_order %0d: dut byte %h grant %0d required %h / %0d",
                         i, wlog.size() > i ? wlog[i] : 8'hxx, glog.size() > i ? glog[i] : -1, 8'h10 + 8'(i % N), i % N);
            else passed++;
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_b [8];
        int exp_g [3];
        exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
        exp_g = '{0, 2, 0};
        apply_reset();
        push_pkt(0, 6, 8'hA0);
        push_pkt(2, 2, 8'hB0);
        drive();
        exp_v = model_out();
        for (int c = 0; c < 100 && !quiet(); c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL burst cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        total++;
        if (wlog.size() != 8) $display("FAIL burst_count: dut %0d required 8", wlog.size()); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wlog.size() <= i || wlog[i] !== exp_b[i]) $display("FAIL burst_byte %0d: dut %p required %h", i, wlog, exp_b[i]); else passed++;
        end
        total++;
        if (glog.size() != 3 || glog[0] != exp_g[0] || glog[1] != exp_g[1] || glog[2] != exp_g[2])
            $display("FAIL burst_grants: dut %p required 0 2 0", glog);
        else passed++;
    endtask

    task automatic test_backpressure();
        int fc = 0;
        bit pf = 0;
        wlog.delete(); glog.delete();
        push_pkt(3, 4, 8'hC0);
        drive();
        exp_v = model_out();
        for (int c = 0; c < 80 && !quiet(); c++) begin
            full_v = wlog.size() >= 1 && fc < 10;
            if (full_v) fc++;
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL bp cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
            if (tx_full_i) begin
                total++;
                if (req_ready_o !== '0 || grant_o !== 4'b1000 || (pf && tx_write_o !== 1'b0))
                    $display("FAIL bp_hold cyc %0d: dut ready %b grant %b write %b required 0000 1000 0", c, req_ready_o, grant_o, tx_write_o);
                else passed++;
            end
            pf = tx_full_i;
        end
        full_v = 0;
        total++;
        if (wlog.size() != 4 || wlog[0] !== 8'hC0 || wlog[1] !== 8'hC1 || wlog[2] !== 8'hC2 || wlog[3] !== 8'hC3)
            $display("FAIL bp_bytes: dut %p required C0 C1 C2 C3", wlog);
        else passed++;
    endtask

    task automatic test_enable();
        wlog.delete(); glog.delete();
        en_v = 0;
        push_pkt(1, 3, 8'hD0);
        drive();
        exp_v = model_out();
        repeat (6) begin
            tick();
            total++;
            if (obs() !== exp_v || grant_o !== '0) $display("FAIL en_low: dut %h required %h", obs(), exp_v); else passed++;
        end
        en_v = 1;
        for (int c = 0; c < 5 && m_own < 0; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL en_grant cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        en_v = 0;
        push_pkt(2, 2, 8'hE0);
        for (int c = 0; c < 40 && (pq[1].size() > 0 || m_own >= 0 || m_wr); c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL en_drop cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        repeat (5) begin
            tick();
            total++;
            if (obs() !== exp_v || busy_o !== 1'b0) $display("FAIL en_idle: dut %h required %h", obs(), exp_v); else passed++;
        end
        en_v = 1;
        for (int c = 0; c < 40 && !quiet(); c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL en_resume cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        total++;
        if (wlog.size() != 5 || wlog[0] !== 8'hD0 || wlog[2] !== 8'hD2 || wlog[3] !== 8'hE0 || wlog[4] !== 8'hE1)
            $display("FAIL en_bytes: dut %p required D0 D1 D2 E0 E1", wlog);
        else passed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push_pkt(2, 3, 8'hF0);
        drive();
        exp_v = model_out();
        for (int c = 0; c < 20 && wlog.size() < 1; c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL rstmid cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        rst_n = 0;
        #1;
        total++;
        if (obs() !== 18'h0) $display("FAIL rstmid_async: dut %h required 0", obs()); else passed++;
        @(posedge clk);
        #1;
        total++;
        if (obs() !== 18'h0) $display("FAIL rstmid_hold: dut %h required 0", obs()); else passed++;
        apply_reset();
        push_pkt(2, 1, 8'hF8);
        push_pkt(0, 1, 8'h0F);
        drive();
        exp_v = model_out();
        for (int c = 0; c < 30 && !quiet(); c++) begin
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL rstmid_after cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        total++;
        if (glog.size() != 2 || glog[0] != 0 || glog[1] != 2 || wlog.size() != 2 || wlog[0] !== 8'h0F || wlog[1] !== 8'hF8)
            $display("FAIL rstmid_order: dut grants %p bytes %p required 0 2 / 0F F8", glog, wlog);
        else passed++;
    endtask

    task automatic test_random();
        int nbytes = 0, len;
        apply_reset();
        rnd = 1;
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < 4; p++) begin
                len = $urandom_range(1, 6);
                push_pkt(k, len, 8'($urandom));
                nbytes += len;
            end
        end
        drive();
        exp_v = model_out();
        for (int c = 0; c < 4000 && !quiet(); c++) begin
            full_v = $urandom_range(7) == 0;
            tick();
            total++;
            if (obs() !== exp_v) $display("FAIL random cyc %0d: dut %h required %h", c, obs(), exp_v); else passed++;
        end
        full_v = 0;
        rnd = 0;
        total++;
        if (!quiet() || wlog.size() != nbytes) $display("FAIL random_count: dut %0d bytes required %0d", wlog.size(), nbytes); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit path among NUM_REQ byte-stream requesters. It sits between the requesters and the transmit FIFO write port (data / write strobe / full), and replaces the direct TDR-write path when several on-chip sources must transmit. A granted requester keeps the transmitter until it ends a packet or reaches a burst cap, so a packet is not interleaved with bytes from other requesters.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- MAX_BURST, default 16: maximum bytes per grant before a forced release, 1..255.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  arbiter enable (tie to the TX enable bit); when low, no new grant is issued.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  NUM_REQ  marks the final byte of a packet.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- tx_full_i  in  1  transmit FIFO full.
- tx_data_o  out  8  byte to the transmit FIFO / TDR.
- tx_write_o  out  1  single-cycle write strobe for tx_data_o.
- grant_o  out  NUM_REQ  one-hot current grant, or zero.
- busy_o  out  1  high while a grant is held (state XFER).

## Operation
- States:
  - IDLE: no grant.
  - XFER: one requester owns the transmitter.
- Round-robin pointer rr_ptr (clog2(NUM_REQ) bits) holds the index of the last requester granted. Reset value is NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - If en_i=1 and any req_valid_i is high, select the first valid index searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_REQ.
  - Register the one-hot grant and go to XFER; beat_cnt is cleared to 0.
  - If en_i=0 or no valid, stay in IDLE.
- XFER:
  - req_ready_o[g] = ~tx_full_i & ~tx_write_o (combinational); all other ready bits are 0.
  - A beat is accepted when req_valid_i[g] & req_ready_o[g]. On acceptance, register tx_data_o = byte g and set tx_write_o = 1 on the next cycle. beat_cnt increments (width clog2(MAX_BURST+1)).
  - Release happens on an accepted beat with req_last_i[g]=1, or with beat_cnt == MAX_BURST-1. Either condition: next state IDLE, grant_o cleared, rr_ptr = g.
  - A requester that deasserts valid mid-packet keeps the grant; there is no timeout.
  - en_i falling during XFER does not revoke the grant. The packet completes, then no new grant is issued.
- tx_data_o holds its last value when tx_write_o=0.
- The requester data path and the FIFO interface carry 8 bits only; the arbiter ignores the data width configured in the line control register.

## Timing
- Reset (async assert) forces:
  - state IDLE, grant_o=0, req_ready_o=0, busy_o=0
  - tx_write_o=0, tx_data_o=8'h00
  - rr_ptr=NUM_REQ-1, beat_cnt=0
- Reset deassertion is synchronous to clk.
- Reset mid-packet abandons the packet; no partial write strobe is issued afterwards.
- Grant latency: a request seen in IDLE at cycle N gives grant_o and busy_o at N+1. The earliest ready is at N+1.
- Accept-to-write latency: an accept at cycle M gives tx_write_o=1 during M+1 only.
- Throughput: at most one byte every 2 cycles, because ready is masked while tx_write_o=1. This also guarantees tx_full_i is current before the next accept, so the FIFO cannot overflow.
- Release: the last beat is accepted at cycle M, the state is IDLE at M+1 (with tx_write_o=1 for that byte), and the next grant is at M+2. There is therefore one dead cycle between packets.
- tx_full_i high: ready stays 0 and the grant is held indefinitely.

## Test plan
- Single requester:
  - Stimulus: requester 1 sends 3 bytes 0x41,0x42,0x43 with last on 0x43.
  - Required response: three one-cycle tx_write_o pulses at least 2 cycles apart carrying 0x41,0x42,0x43 in order; grant_o=4'b0010 throughout; busy_o falls the cycle after the last accept; rr_ptr=1.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, 1-byte packets (last=1), data = 0x10+k.
  - Required response: grant order 0,1,2,3,0,…; tx_data_o sequence 0x10,0x11,0x12,0x13,0x10.
- Burst cap:
  - Stimulus: MAX_BURST=4; requester 0 sends 6 bytes with last only on byte 6; requester 2 is also valid.
  - Required response: 4 bytes from requester 0, then the grant moves to requester 2, then requester 0 regains the grant for its remaining 2 bytes.
- Backpressure:
  - Stimulus: hold tx_full_i=1 for 10 cycles mid-packet.
  - Required response: req_ready_o=0 and no tx_write_o while full; the grant is held; transfer resumes the cycle after tx_full_i falls with no byte lost or duplicated.
- Enable and reset:
  - en_i=0 with requests pending: no grant is issued.
  - en_i dropped mid-packet: the packet completes, then the arbiter stays IDLE.
  - rst_n asserted mid-packet: all outputs go to reset values immediately, and requester 0 is granted first after release.
